serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, the maximum payload bytes per frame (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, the inter-byte idle limit in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  received byte from the serial port receiver.
REQ-007 SHALL have port rx_dv  input  1  single-cycle strobe qualifying rx_data.
REQ-008 SHALL have port out_data  output  8  payload byte of a validated frame.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_last  output  1  marks the final payload byte; qualified by out_valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts a byte when out_valid & out_ready.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on frame rejection.
REQ-013 SHALL have port err_code  output  2  reason, valid with frame_err: 1 bad length, 2 bad checksum, 3 timeout.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped during EMIT.

Function
REQ-015 Frame format SHALL be SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK = (LEN + sum of payload) mod 256.
REQ-016 FSM states SHALL be IDLE, LEN, PAYLOAD, CHK, EMIT; all transitions occur only on rx_dv, except the EMIT exit and timeout.
REQ-017 IDLE: rx_dv with rx_data==SYNC_BYTE -> LEN; any other byte ignored with no error.
REQ-018 LEN: rx_dv with LEN==0 or LEN>MAX_LEN -> IDLE, frame_err with err_code=1; otherwise store LEN, sum=LEN, index=0 -> PAYLOAD.
REQ-019 PAYLOAD: each rx_dv writes buf[index], adds the byte to the 8-bit sum (wraps mod 256), increments index; the write of index LEN-1 -> CHK.
REQ-020 CHK: rx_dv with rx_data==sum -> EMIT with read index 0; mismatch -> IDLE, frame_err with err_code=2.
REQ-021 EMIT: out_valid=1, out_data=buf[rd], out_last=(rd==LEN-1); rd increments on each handshake; handshake with out_last -> IDLE, out_valid low next cycle.
REQ-022 out_valid SHALL rise the cycle after the accepted CHK strobe; out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-023 rx_dv in EMIT (including a simultaneous final handshake) SHALL drop the byte and pulse overrun the next cycle; output stream unaffected.
REQ-024 frame_err, err_code and overrun SHALL be registered, asserting one cycle after the causing event; err_code holds its last value otherwise.
REQ-025 A SYNC_BYTE value received in LEN, PAYLOAD or CHK SHALL be treated as ordinary data.
REQ-026 Output SHALL never present bytes from a frame that failed validation.

Reset
REQ-027 On rst: state=IDLE, out_valid=0, out_last=0, out_data=0, frame_err=0, err_code=0, overrun=0, counters/sum=0.
REQ-028 rst mid-frame or mid-EMIT SHALL abort immediately with no error pulse; buffer contents need not be cleared.

Configuration
REQ-029 Macro SERIAL_FRAME_TIMEOUT_EN defined: an idle counter runs in LEN/PAYLOAD/CHK, clears on every rx_dv and on state entry; reaching TIMEOUT_CYCLES -> IDLE, frame_err with err_code=3.
REQ-030 Macro SERIAL_FRAME_TIMEOUT_EN undefined: no counter logic; the FSM waits indefinitely for bytes; err_code 3 is never produced.

Verification
REQ-031 Bytes A5 03 11 22 33 69, out_ready=1 -> out_data 11,22,33 on consecutive cycles, out_last on 33, no frame_err.
REQ-032 A5 03 11 22 33 68 -> frame_err with err_code=2, out_valid never asserts; a following good frame is accepted.
REQ-033 A5 00 and A5 11 (17>MAX_LEN) -> frame_err with err_code=1 each; A5 02 FF FF 00 (sum wrap) -> outputs FF,FF.
REQ-034 Good frame with out_ready low 5 cycles on byte 2 -> out_data=22 held all 5 cycles; no byte lost or duplicated.
REQ-035 rx_dv with 0x55 during EMIT, including the last-handshake cycle -> overrun pulse, stream 11,22,33 intact, FSM returns to IDLE.
REQ-036 With SERIAL_FRAME_TIMEOUT_EN: A5 02 11 then 100000 idle cycles -> frame_err with err_code=3; rst asserted mid-PAYLOAD -> IDLE, no pulse.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: SYNC, LEN, payload, CHK -> validated byte stream with valid/ready output.
// Optional inter-byte timeout enabled by defining SERIAL_FRAME_TIMEOUT_EN.
module serial_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IDX_W;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("serial_frame_rx: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [IDX_W-1:0] wr_q, wr_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] rd_nxt;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             overrun_q, overrun_d;

`ifdef SERIAL_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_q, idle_d;
`endif

  assign rd_nxt = rd_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    mem_d       = mem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dv && rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_dv) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else begin
            len_d   = rx_data;
            sum_d   = rx_data;
            wr_d    = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_dv) begin
          mem_d[wr_q] = rx_data;
          sum_d       = sum_q + rx_data;
          wr_d        = wr_q + 1'b1;
          if (8'(wr_q) == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_dv) begin
          if (rx_data == sum_q) begin
            state_d     = S_EMIT;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = mem_q[0];
            out_last_d  = (len_q == 8'd1);
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
      end
      S_EMIT: begin
        // Nothing is accepted while draining; a strobe here is lost and flagged.
        overrun_d = rx_dv;
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_d       = rd_nxt;
            out_data_d = mem_q[rd_nxt];
            out_last_d = (8'(rd_nxt) == len_q - 8'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SERIAL_FRAME_TIMEOUT_EN
    // Every entry into LEN/PAYLOAD/CHK happens on a strobe, so clearing on rx_dv covers state entry.
    idle_d = '0;
    if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) && !rx_dv) begin
      if (idle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        err_code_d  = 2'd3;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_FRAME_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_FRAME_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  // Payload storage needs no reset: it is always rewritten before being read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed cases plus randomized frames against a frame-level model.
module tb_serial_frame_rx;
  localparam int MAXL = 16;
  localparam int TO   = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  always #5 clk = ~clk;

  serial_frame_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_err(frame_err), .err_code(err_code), .overrun(overrun)
  );

  typedef struct packed {logic [7:0] d; logic l;} beat_t;

  int         checks = 0;
  int         errors = 0;
  beat_t      exp_q[$];
  logic [1:0] err_q[$];
  int         exp_ovr = 0;
  int         got_ovr = 0;
  int         rdy_mode = 1;   // 0 random, 1 high, 2 low, 3 left to the caller
  bit         gap_en = 1'b0;
  logic [7:0] pay [0:255];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboards.
  beat_t      mon_e;
  logic [1:0] mon_c;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {23'd0, out_data, out_last}, {23'd0, prev_data, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_q.pop_front();
          chk("stream_byte", {23'd0, out_data, out_last}, {23'd0, mon_e.d, mon_e.l});
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) chk("unexpected_err", {30'd0, err_code}, 32'hFFFF_FFFF);
        else begin
          mon_c = err_q.pop_front();
          chk("err_code", {30'd0, err_code}, {30'd0, mon_c});
        end
      end
      if (overrun) got_ovr++;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (out_valid && n < 500) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, out_valid}, 32'd0);
  endtask

  // Expected result comes straight from the frame rules: checksum = (LEN + sum) mod 256.
  task automatic send_frame(input int len, input logic [7:0] chk_adj, input bit expect_out);
    logic [7:0] s;
    s = 8'(len);
    for (int i = 0; i < len; i++) s = s + pay[i];
    if (expect_out) begin
      if (chk_adj == 8'd0) for (int i = 0; i < len; i++) exp_q.push_back({pay[i], i == len - 1});
      else err_q.push_back(2'd2);
    end
    send_byte(8'hA5);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(pay[i]);
      if (gap_en) repeat ($urandom_range(0, 1)) tick();
    end
    send_byte(s + chk_adj);
    if (expect_out && chk_adj == 8'd0) begin
      chk("valid_rise", {31'd0, out_valid}, 32'd1);
      chk("first_byte", {24'd0, out_data}, {24'd0, pay[0]});
    end
  endtask

  task automatic rand_frame();
    int kind;
    int len;
    logic [7:0] b;
    wait_idle();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
    end
    kind = $urandom_range(0, 5);
    if (kind == 0) begin
      err_q.push_back(2'd1);
      send_byte(8'hA5);
      send_byte(8'h00);
    end else if (kind == 1) begin
      err_q.push_back(2'd1);
      send_byte(8'hA5);
      send_byte(8'($urandom_range(MAXL + 1, 255)));
    end else begin
      len = $urandom_range(1, MAXL);
      for (int i = 0; i < len; i++) begin
        pay[i] = 8'($urandom);
        if ($urandom_range(0, 7) == 0) pay[i] = 8'hA5;
      end
      send_frame(len, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'd0, 1'b1);
    end
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pay[0] = a; pay[1] = b; pay[2] = c;
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic good frame, then bad checksum followed by a good frame.
    set3(8'h11, 8'h22, 8'h33);
    send_frame(3, 8'd0, 1'b1);
    wait_idle();
    send_frame(3, 8'hFF, 1'b1);
    tick();
    chk("badchk_no_valid", {31'd0, out_valid}, 32'd0);
    send_frame(3, 8'd0, 1'b1);
    wait_idle();

    // Length errors and checksum wrap.
    err_q.push_back(2'd1); send_byte(8'hA5); send_byte(8'h00);
    err_q.push_back(2'd1); send_byte(8'hA5); send_byte(8'h11);
    pay[0] = 8'hFF; pay[1] = 8'hFF;
    send_frame(2, 8'd0, 1'b1);
    wait_idle();
    tick();

    // Consumer stall on the second byte.
    rdy_mode = 3; out_ready = 1'b0;
    set3(8'h11, 8'h22, 8'h33);
    send_frame(3, 8'd0, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_data", {24'd0, out_data}, 32'h22);
    end
    out_ready = 1'b1; tick(); tick();
    chk("stall_done", {31'd0, out_valid}, 32'd0);

    // Strobes during EMIT, the last one coinciding with the final handshake.
    rdy_mode = 1;
    send_frame(3, 8'd0, 1'b1);
    repeat (3) send_byte(8'h55);
    exp_ovr += 3;
    chk("emit_exit", {31'd0, out_valid}, 32'd0);
    tick();

    // Reset mid-payload and mid-emit: abort silently.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst_mid_no_err", {31'd0, frame_err}, 32'd0);
    rdy_mode = 2;
    send_frame(3, 8'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_emit_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_emit_data", {24'd0, out_data}, 32'd0);
    rdy_mode = 1; tick();
    send_frame(3, 8'd0, 1'b1);
    wait_idle();

`ifdef SERIAL_FRAME_TIMEOUT_EN
    err_q.push_back(2'd3);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    repeat (TO - 1) tick();
    chk("timeout_early", err_q.size(), 32'd1);
    repeat (3) tick();
    chk("timeout_fired", err_q.size(), 32'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (TO + 5) tick();
`endif

    rdy_mode = 0; gap_en = 1'b1;
    repeat (150) rand_frame();
    wait_idle();
    repeat (5) tick();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("err_q_empty", err_q.size(), 32'd0);
    chk("overrun_count", got_ovr, exp_ovr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=hung exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule
